// File: rtl/ps2_tx.sv
// ---------------------------------------------------------------------------
// ps2_tx -- host-to-device PS/2 transmitter
//
// Sends one command byte (for example 0xED "set LEDs" or 0xFF "reset") from
// the FPGA to a PS/2 keyboard. The block:
//   * holds ps2_clk low for RQST_CYCLES to request the bus (request-to-send),
//   * drives the start bit, then shifts out d0..d7 and odd parity on the
//     falling edges of the device-generated clock,
//   * releases ps2_data for the stop bit and samples the device ACK on the
//     eleventh falling edge,
//   * aborts with an error if the device stops clocking for TIMEOUT_CYCLES.
// Both PS/2 lines are open-drain: they are only ever driven 0 or released.
//
// Ports
//   clk          in   system clock, all logic on its rising edge
//   reset        in   synchronous, active-low reset
//   wr_ps2       in   single-cycle start request, din sampled in that cycle
//   din[7:0]     in   command byte to send
//   rx_idle      in   PS/2 receiver is not in the middle of a frame
//   tx_idle      out  FSM is in IDLE and accepting requests
//   tx_done_tick out  one-cycle pulse at the end of every started transfer
//   tx_err       out  qualified by tx_done_tick: 1 = no ACK or timed out
//   dbg_state    out  current FSM state encoding (S_* constants below)
//   ps2_clk      io   PS/2 clock line (0 or Z)
//   ps2_data     io   PS/2 data line (0 or Z)
//
// Handshake: a request is taken only in a cycle where wr_ps2 = 1, tx_idle = 1
// and rx_idle = 1. A request in any other cycle is dropped without effect;
// completion is signalled solely by tx_done_tick.
// ---------------------------------------------------------------------------
module ps2_tx #(
    parameter int RQST_CYCLES    = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       rx_idle,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err,
    output logic [2:0] dbg_state,
    inout  wire        ps2_clk,
    inout  wire        ps2_data
);

    // Counter widths: each counter only has to hold (parameter - 1).
    localparam int RQ_W = (RQST_CYCLES    > 2) ? $clog2(RQST_CYCLES)    : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [RQ_W-1:0] RQ_LOAD = RQ_W'(RQST_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // FSM state encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RQST  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
    logic [1:0] r_clk_sync;
    logic [7:0] r_clk_filt;
    logic       r_clk_f;
    logic [1:0] r_data_sync;
    logic       w_fall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clk_sync  <= 2'b11;
            r_clk_filt  <= 8'hFF;
            r_clk_f     <= 1'b1;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_clk_filt  <= {r_clk_filt[6:0], r_clk_sync[1]};
            r_data_sync <= {r_data_sync[0], ps2_data};
            // Hysteresis: the filtered clock only moves after eight equal
            // samples, so short glitches leave it untouched.
            if (r_clk_filt == 8'hFF) begin
                r_clk_f <= 1'b1;
            end else if (r_clk_filt == 8'h00) begin
                r_clk_f <= 1'b0;
            end
        end
    end

    // High for exactly the cycle in which the filtered clock is about to
    // change from 1 to 0 (ten cycles after the pin edge).
    assign w_fall = r_clk_f && (r_clk_filt == 8'h00);

    // -----------------------------------------------------------------------
    // Transfer state machine
    // -----------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [8:0]      r_frame;      // {parity, d7..d0}, bit 0 is on the line
    logic [3:0]      r_bit_idx;
    logic [RQ_W-1:0] r_rqst_cnt;
    logic [TO_W-1:0] r_wdog;
    logic            r_done;
    logic            r_err;
    logic            w_on_wire;    // states in which the device is clocking
    logic            w_timeout;

    assign w_on_wire = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_STOP);
    assign w_timeout = w_on_wire && (r_wdog == TO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_frame    <= 9'h1FF;
            r_bit_idx  <= 4'd0;
            r_rqst_cnt <= '0;
            r_wdog     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // tx_done_tick / tx_err are single-cycle pulses by default.
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_timeout) begin
                // Device went silent: give up, release the bus, report error.
                r_state <= S_IDLE;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
                r_wdog  <= '0;
            end else begin
                if (w_on_wire) begin
                    r_wdog <= w_fall ? '0 : r_wdog + 1'b1;
                end

                case (r_state)
                    S_IDLE: begin
                        if (wr_ps2 && rx_idle) begin
                            r_frame    <= {~^din, din};
                            r_rqst_cnt <= RQ_LOAD;
                            r_state    <= S_RQST;
                        end
                    end

                    S_RQST: begin
                        if (r_rqst_cnt == '0) begin
                            r_state <= S_START;
                            r_wdog  <= '0;
                        end else begin
                            r_rqst_cnt <= r_rqst_cnt - 1'b1;
                        end
                    end

                    S_START: begin
                        if (w_fall) begin
                            r_bit_idx <= 4'd0;
                            r_state   <= S_DATA;
                        end
                    end

                    S_DATA: begin
                        // Falls 2..9 advance to d1..d7 then parity; fall 10
                        // (index 8, parity on the wire) moves to the stop bit.
                        if (w_fall) begin
                            if (r_bit_idx == 4'd8) begin
                                r_state <= S_STOP;
                            end else begin
                                r_frame   <= {1'b1, r_frame[8:1]};
                                r_bit_idx <= r_bit_idx + 4'd1;
                            end
                        end
                    end

                    S_STOP: begin
                        // Device pulls data low as ACK during the 11th clock;
                        // a line still high means the ACK is missing.
                        if (w_fall) begin
                            r_done  <= 1'b1;
                            r_err   <= r_data_sync[1];
                            r_state <= S_IDLE;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Open-drain line drivers
    // -----------------------------------------------------------------------
    logic w_clk_low;
    logic w_data_low;

    assign w_clk_low  = (r_state == S_RQST);
    assign w_data_low = (r_state == S_START) ||
                        ((r_state == S_DATA) && !r_frame[0]);

    assign ps2_clk  = w_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = w_data_low ? 1'b0 : 1'bz;

    // -----------------------------------------------------------------------
    // Status outputs
    // -----------------------------------------------------------------------
    assign tx_idle      = (r_state == S_IDLE);
    assign tx_done_tick = r_done;
    assign tx_err       = r_err;
    assign dbg_state    = r_state;

endmodule
